axis_frame_source: RTL and testbench
====================================

// Module: axis_frame_source
// PURPOSE
//  Reads one 8-bit greyscale frame from a synchronous-read pixel memory in raster order.
//  Transmits it as an AXI-Stream master, one pixel per beat, tlast on the final pixel.
//  Acts as the transmitting end that feeds the sharpen filter's s_axis slave port.
//  Honours back-pressure through a 2-entry prefetch FIFO; sustains 1 beat/clk while tready=1.
// PARAMETERS
//  IMG_W   640  pixels per line
//  IMG_H   480  lines per frame
//  ADDR_W  19   memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk            in   1       clock
//  rstn           in   1       synchronous active-low reset
//  start          in   1       begin a frame; sampled only in IDLE
//  busy           out  1       high from frame start until last beat accepted
//  done           out  1       one-cycle pulse after the tlast beat handshakes
//  mem_en         out  1       memory read enable
//  mem_addr       out  ADDR_W  read address, 0 .. IMG_W*IMG_H-1
//  mem_rdata      in   8       read data, valid exactly 1 cycle after mem_en
//  m_axis_tdata   out  8       pixel
//  m_axis_tkeep   out  1       equals m_axis_tvalid
//  m_axis_tlast   out  1       high with the beat for address IMG_W*IMG_H-1
//  m_axis_tvalid  out  1       beat valid
//  m_axis_tready  in   1       downstream ready
// BEHAVIOUR
//  Interface: reset rstn, synchronous, active-low; clock clk.
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; read address counter 0; in-flight flag 0.
//  FSM states:
//   IDLE: start=1 -> RUN; busy<=1; address counter <= 0.
//   RUN: all reads issued and FIFO empty after last handshake -> DONE.
//   DONE: done=1 for this one cycle; busy<=0; -> IDLE.
//  start while in RUN/DONE is ignored.
//  Read issue, in RUN only:
//   mem_en=1 when addr < IMG_W*IMG_H and (fifo_count + inflight - pop) < 2.
//   pop = m_axis_tvalid & m_axis_tready.
//   Address counter increments by 1 per mem_en; no wrap within a frame.
//  Capture: inflight=1 in the cycle after mem_en. mem_rdata is written to the FIFO tail at
//   the end of that cycle, together with tlast = (its address == IMG_W*IMG_H-1).
//  Output: tvalid = FIFO non-empty; tdata/tlast = FIFO head, registered.
//   tdata, tlast, tvalid, tkeep are held stable while tvalid=1 and tready=0.
//  Latency: start sampled at edge E0 -> mem_en/addr=0 in cycle E0..E1 -> tvalid=1 from E2.
//  Throughput: with tready held 1, one beat every clk; IMG_W*IMG_H beats in
//   IMG_W*IMG_H+2 cycles from start.
//  Simultaneous push and pop on a full or 1-entry FIFO: both occur; count unchanged.
//   Read issue must never overflow the FIFO.
//  done asserts the cycle after the tlast handshake; busy falls on the same edge that
//   raises done.
//  rstn low mid-frame: frame is abandoned and all state returns to reset values next edge.
//   No stale read data may appear after reset release.
// CONFIGURATION
//  AXIS_SRC_SOF_EN defined: adds output port m_axis_tuser (1 bit).
//   It is high only on the beat for address 0 (start of frame) and held with that beat
//   under back-pressure.
//  AXIS_SRC_SOF_EN undefined: no m_axis_tuser port; all other behaviour identical.
// TESTING (IMG_W=4, IMG_H=3, mem[i]=i+16)
//  tready=1, start pulse -> 12 beats tdata 16..27 on consecutive cycles, tvalid first at
//   start+2, tlast only on 27, done pulse next cycle.
//  tready toggled 1,0,0,1 repeating -> same 12 values in order, no drop or duplicate,
//   outputs stable when tready=0, FIFO never >2.
//  tready=0 for 20 cycles after start -> exactly 2 reads issued; tdata=16 held; then
//   tready=1 resumes the full frame.
//  rstn low at beat 5 for 1 cycle -> all outputs 0; new start -> frame restarts at tdata=16.
//  start pulsed during RUN -> ignored, single frame of 12 beats.
//  AXIS_SRC_SOF_EN defined -> m_axis_tuser=1 only with tdata=16, including under
//   back-pressure.

Source files
------------

// File: rtl/axis_frame_source.sv
// Purpose: reads one 8-bit greyscale frame from a sync-read pixel memory in raster order and emits it as AXI-Stream.
// Latency: start sampled at edge E0 -> first read in cycle E0..E1 -> tvalid from E2; 1 beat/clk while tready=1.
// Backpressure: a 2-entry prefetch FIFO plus in-flight read are capped at 2; beats hold while tready=0. Option: AXIS_SRC_SOF_EN adds m_axis_tuser (SOF).
module axis_frame_source #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tkeep,
  output logic              m_axis_tlast,
`ifdef AXIS_SRC_SOF_EN
  output logic              m_axis_tuser,
`endif
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam int NPIX = IMG_W * IMG_H;
  // One extra counter bit so the "all issued" value never aliases to 0,
  // even when 2**ADDR_W equals the pixel count exactly.
  localparam logic [ADDR_W:0] END_A  = (ADDR_W+1)'(NPIX);
  localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
`ifdef AXIS_SRC_SOF_EN
    logic       sof;
`endif
    logic       last;
    logic [7:0] data;
  } beat_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic              inflight_q;
  logic              inflight_last_q;
`ifdef AXIS_SRC_SOF_EN
  logic              inflight_sof_q;
`endif
  beat_t             head_q, head_d;
  beat_t             tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  beat_t             wbeat;

  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tkeep  = m_axis_tvalid;
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tlast  = head_q.last;
`ifdef AXIS_SRC_SOF_EN
  assign m_axis_tuser  = head_q.sof;
`endif

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = inflight_q;

  // Entries committed to the FIFO once this cycle's pop is taken: stored beats plus the read in flight.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (addr_q < END_A) && (occ < 3'd2);

  assign mem_en   = issue;
  assign mem_addr = addr_q[ADDR_W-1:0];
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

  // Beat arriving from memory this cycle, tagged with the flags of the address that produced it.
  always_comb begin
    wbeat      = '0;
    wbeat.data = mem_rdata;
    wbeat.last = inflight_last_q;
`ifdef AXIS_SRC_SOF_EN
    wbeat.sof  = inflight_sof_q;
`endif
  end

  // Two-entry FIFO next state; head is the registered output beat.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = wbeat;
        else                 tail_d = wbeat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = wbeat;
        end else begin
          head_d = tail_q;
          tail_d = wbeat;
        end
      end
      default: ;
    endcase
  end

  // Frame FSM and read address counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (issue) addr_d = addr_q + 1'b1;
        if ((addr_q == END_A) && !inflight_q && (count_d == 2'd0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight read so no stale pixel surfaces afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef AXIS_SRC_SOF_EN
      inflight_sof_q  <= 1'b0;
`endif
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (addr_q == LAST_A);
`ifdef AXIS_SRC_SOF_EN
      inflight_sof_q  <= issue && (addr_q == '0);
`endif
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Purpose: directed bench for axis_frame_source with a 4x3 frame and mem[i]=i+16.
// Latency: checks first beat at start+2, full-rate frame done at start+14.
// Backpressure: exercises tready patterns, long stall, mid-frame reset, ignored start; SOF checks under AXIS_SRC_SOF_EN.
module tb_axis_frame_source;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'd0;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tkeep;
  logic              m_axis_tlast;
`ifdef AXIS_SRC_SOF_EN
  logic              m_axis_tuser;
`endif
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  axis_frame_source #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_SRC_SOF_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel memory: mem[i] = i + 16.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= 8'(32'(mem_addr) + 16);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_tvalid"}, int'(m_axis_tvalid), 0);
    chk({pfx, "_tkeep"},  int'(m_axis_tkeep), 0);
    chk({pfx, "_tlast"},  int'(m_axis_tlast), 0);
    chk({pfx, "_tdata"},  int'(m_axis_tdata), 0);
    chk({pfx, "_busy"},   int'(busy), 0);
    chk({pfx, "_done"},   int'(done), 0);
    chk({pfx, "_mem_en"}, int'(mem_en), 0);
    chk({pfx, "_addr"},   int'(mem_addr), 0);
`ifdef AXIS_SRC_SOF_EN
    chk({pfx, "_tuser"},  int'(m_axis_tuser), 0);
`endif
  endtask

  // mode 0: tready=1; 1: tready 1,0,0,1 repeating; 2: tready=0 for 20 cycles; 4: tready=1, start pulsed in RUN and DONE.
  task automatic run_frame(input int mode);
    int         nbeat = 0;
    int         issued = 0;
    int         popped = 0;
    int         first_vld = -1;
    int         last_hs = -1;
    int         done_cyc = -1;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       plast = 1'b0;
    logic       puser = 1'b0;
    logic [7:0] pdat = 8'd0;
    @(negedge clk);
    start = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       m_axis_tready = (cyc >= 20);
        default: m_axis_tready = 1'b1;
      endcase
      start = (mode == 4) && (cyc == 5 || cyc == 14);
      #1;
      chk("tkeep_eq_tvalid", int'(m_axis_tkeep), int'(m_axis_tvalid));
      if (m_axis_tvalid && first_vld < 0) begin
        first_vld = cyc;
        chk("first_tvalid_cycle", cyc, 2);
      end
      if (pv && !pr) begin
        chk("hold_tvalid", int'(m_axis_tvalid), 1);
        chk("hold_tdata", int'(m_axis_tdata), int'(pdat));
        chk("hold_tlast", int'(m_axis_tlast), int'(plast));
`ifdef AXIS_SRC_SOF_EN
        chk("hold_tuser", int'(m_axis_tuser), int'(puser));
`endif
      end
      chk("occupancy_le2", int'((issued - popped) <= 2), 1);
      if (mem_en) begin
        chk("rd_addr", int'(mem_addr), issued);
        issued++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("tdata", int'(m_axis_tdata), 16 + nbeat);
        chk("tlast", int'(m_axis_tlast), int'(nbeat == NPIX - 1));
`ifdef AXIS_SRC_SOF_EN
        chk("tuser_sof", int'(m_axis_tuser), int'(nbeat == 0));
`endif
        nbeat++;
        popped++;
        last_hs = cyc;
      end
      if (mode == 2 && cyc == 19) chk("reads_while_stalled", issued, 2);
      if (done) begin
        done_cyc = cyc;
        chk("done_after_tlast", cyc, last_hs + 1);
        chk("busy_low_with_done", int'(busy), 0);
        if (mode == 0 || mode == 4) chk("done_cycle_full_rate", cyc, NPIX + 2);
      end else begin
        chk("busy_in_frame", int'(busy), 1);
      end
      pv    = m_axis_tvalid;
      pr    = m_axis_tready;
      pdat  = m_axis_tdata;
      plast = m_axis_tlast;
`ifdef AXIS_SRC_SOF_EN
      puser = m_axis_tuser;
`endif
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("beat_count", nbeat, NPIX);
    chk("read_count", issued, NPIX);
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", int'(done), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_read", int'(mem_en), 0);
      chk("idle_no_tvalid", int'(m_axis_tvalid), 0);
      chk("idle_not_busy", int'(busy), 0);
    end
  endtask

  task automatic abort_frame();
    @(negedge clk);
    start = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("pre_abort_tdata", int'(m_axis_tdata), 21);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_tvalid", int'(m_axis_tvalid), 0);
      chk("post_abort_mem_en", int'(mem_en), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    abort_frame();
    run_frame(0);
    run_frame(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
